// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, byte width and
// default per-requester buffering.
package uart_tx_arbiter_pkg;

  localparam int DEFAULT_FIFO_DEPTH = 4;
  localparam int BYTE_W             = 8;

  typedef enum logic [1:0] {
    sIDLE  = 2'b00,
    sSTART = 2'b01,
    sBUSY  = 2'b10
  } txStateT;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous show-ahead byte FIFO; oData always presents the head entry.
module byte_fifo
  import uart_tx_arbiter_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              iClk,
  input  logic              iRstN,
  input  logic              iPush,
  input  logic [BYTE_W-1:0] iData,
  input  logic              iPop,
  output logic [BYTE_W-1:0] oData,
  output logic              oFull,
  output logic              oEmpty,
  output logic [CNT_W-1:0]  oCount
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic              doPush;
  logic              doPop;

  assign oFull  = (oCount == CNT_FULL);
  assign oEmpty = (oCount == '0);
  assign doPush = iPush && !oFull;
  assign doPop  = iPop && !oEmpty;
  assign oData  = mem[rdPtr];

  always_ff @(posedge iClk) begin
    if (doPush) mem[wrPtr] <= iData;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      oCount <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   oCount <= oCount + CNT_W'(1);
        2'b01:   oCount <= oCount - CNT_W'(1);
        default: oCount <= oCount;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester byte arbiter in front of one UART transmitter: per-requester FIFOs,
// round-robin grant, and a start/busy handshake with the transmitter.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic              iClk,
  input  logic              iRstN,
  input  logic              iValid0,
  input  logic              iValid1,
  input  logic [BYTE_W-1:0] iByte0,
  input  logic [BYTE_W-1:0] iByte1,
  output logic              oReady0,
  output logic              oReady1,
  output logic              oTxStart,
  output logic [BYTE_W-1:0] oTxByte,
  input  logic              iTxDone,
  output logic              oBusy,
  output logic              oSrc
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]        rstSync;
  logic              rstN;
  txStateT           state;
  logic              lastGrant;
  logic              has0;
  logic              has1;
  logic              grant;
  logic              popReq;
  logic              full0;
  logic              full1;
  logic              empty0;
  logic              empty1;
  logic [CNT_W-1:0]  count0;
  logic [CNT_W-1:0]  count1;
  logic [BYTE_W-1:0] head0;
  logic [BYTE_W-1:0] head1;

  // Reset asserts asynchronously but releases only after two clean clock edges.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) rstSync <= 2'b00;
    else        rstSync <= {rstSync[0], 1'b1};
  end
  assign rstN = rstSync[1];

  byte_fifo #(.DEPTH(FIFO_DEPTH)) uFifo0 (
    .iClk   (iClk),
    .iRstN  (rstN),
    .iPush  (iValid0),
    .iData  (iByte0),
    .iPop   (popReq && !grant),
    .oData  (head0),
    .oFull  (full0),
    .oEmpty (empty0),
    .oCount (count0)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) uFifo1 (
    .iClk   (iClk),
    .iRstN  (rstN),
    .iPush  (iValid1),
    .iData  (iByte1),
    .iPop   (popReq && grant),
    .oData  (head1),
    .oFull  (full1),
    .oEmpty (empty1),
    .oCount (count1)
  );

  assign oReady0 = !full0;
  assign oReady1 = !full1;
  assign has0    = !empty0;
  assign has1    = !empty1;

  always_comb begin
    assert (empty0 == (count0 == '0));
    assert (empty1 == (count1 == '0));
  end

  // With both requesters waiting the one not served last wins; otherwise the only one waiting.
  assign grant  = (has0 && has1) ? !lastGrant : has1;
  assign popReq = (state == sIDLE) && (has0 || has1);

  always_ff @(posedge iClk or negedge rstN) begin
    if (!rstN) begin
      state     <= sIDLE;
      oTxStart  <= 1'b0;
      oTxByte   <= '0;
      oBusy     <= 1'b0;
      oSrc      <= 1'b0;
      lastGrant <= 1'b1;
    end else begin
      case (state)
        sIDLE: begin
          if (popReq) begin
            oTxByte  <= grant ? head1 : head0;
            oSrc     <= grant;
            oTxStart <= 1'b1;
            oBusy    <= 1'b1;
            state    <= sSTART;
          end
        end
        sSTART: begin
          oTxStart <= 1'b0;
          state    <= sBUSY;
        end
        sBUSY: begin
          if (iTxDone) begin
            lastGrant <= oSrc;
            oBusy     <= 1'b0;
            state     <= sIDLE;
          end
        end
        default: begin
          oTxStart <= 1'b0;
          oBusy    <= 1'b0;
          state    <= sIDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queue-based frame model checked every cycle,
// plus literal expectations for each scenario.
module tb_uart_tx_arbiter;

  localparam int DEPTH = 4;

  logic       iClk    = 1'b0;
  logic       iRstN   = 1'b1;
  logic       iValid0 = 1'b0;
  logic       iValid1 = 1'b0;
  logic [7:0] iByte0  = 8'h00;
  logic [7:0] iByte1  = 8'h00;
  logic       iTxDone = 1'b0;
  logic       oReady0;
  logic       oReady1;
  logic       oTxStart;
  logic [7:0] oTxByte;
  logic       oBusy;
  logic       oSrc;

  int nVec = 0;
  int nMis = 0;

  // Model state: accepted bytes per requester and the frame currently on the wire.
  logic [7:0] mq0[$];
  logic [7:0] mq1[$];
  bit         mInFrame;
  bit         mStarting;
  bit         mSrc;
  bit         mLast;
  logic [7:0] mByte;
  int         mHold;

  logic [7:0] txLog[$];
  bit         srcLog[$];

  logic [7:0] expT2 [6] = '{8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23};
  bit         expS2 [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] expT3 [5] = '{8'h40, 8'h31, 8'h32, 8'h33, 8'h34};
  bit         expS3 [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  uart_tx_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .iClk     (iClk),
    .iRstN    (iRstN),
    .iValid0  (iValid0),
    .iValid1  (iValid1),
    .iByte0   (iByte0),
    .iByte1   (iByte1),
    .oReady0  (oReady0),
    .oReady1  (oReady1),
    .oTxStart (oTxStart),
    .oTxByte  (oTxByte),
    .iTxDone  (iTxDone),
    .oBusy    (oBusy),
    .oSrc     (oSrc)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string name, input int act, input int exp);
    nVec++;
    if (act != exp) begin
      nMis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic void mReset();
    mq0.delete();
    mq1.delete();
    mInFrame  = 1'b0;
    mStarting = 1'b0;
    mSrc      = 1'b0;
    mLast     = 1'b1;
    mByte     = 8'h00;
    mHold     = 2;
  endfunction

  // One clock edge of the specified behaviour, using inputs captured at that edge.
  function automatic void mStep(input bit v0, input logic [7:0] b0,
                                input bit v1, input logic [7:0] b1, input bit done);
    bit acc0;
    bit acc1;
    acc0 = v0 && (mq0.size() < DEPTH);
    acc1 = v1 && (mq1.size() < DEPTH);
    if (mInFrame && mStarting) begin
      mStarting = 1'b0;
    end else if (mInFrame) begin
      if (done) begin
        mInFrame = 1'b0;
        mLast    = mSrc;
      end
    end else if (mq0.size() > 0 || mq1.size() > 0) begin
      if (mq0.size() > 0 && mq1.size() > 0) mSrc = !mLast;
      else                                  mSrc = (mq0.size() == 0);
      mByte     = mSrc ? mq1.pop_front() : mq0.pop_front();
      mInFrame  = 1'b1;
      mStarting = 1'b1;
    end
    if (acc0) mq0.push_back(b0);
    if (acc1) mq1.push_back(b1);
  endfunction

  initial begin : compareProc
    bit         sv0;
    bit         sv1;
    bit         sDone;
    logic [7:0] sb0;
    logic [7:0] sb1;
    mReset();
    mHold = 0;
    forever begin
      @(posedge iClk);
      sv0 = iValid0; sb0 = iByte0; sv1 = iValid1; sb1 = iByte1; sDone = iTxDone;
      if (!iRstN)         mReset();
      else if (mHold > 0) mHold--;
      else                mStep(sv0, sb0, sv1, sb1, sDone);
      @(negedge iClk);
      if (!iRstN) mReset();
      check("cmp_start",  32'(oTxStart), 32'(mStarting));
      check("cmp_busy",   32'(oBusy),    32'(mInFrame));
      check("cmp_src",    32'(oSrc),     32'(mSrc));
      check("cmp_byte",   32'(oTxByte),  32'(mByte));
      check("cmp_ready0", 32'(oReady0),  32'(mq0.size() < DEPTH));
      check("cmp_ready1", 32'(oReady1),  32'(mq1.size() < DEPTH));
      if (oTxStart) begin
        txLog.push_back(oTxByte);
        srcLog.push_back(oSrc);
      end
    end
  end

  function automatic int logByte(input int i);
    return (i < txLog.size()) ? 32'(txLog[i]) : -1;
  endfunction

  function automatic int logSrc(input int i);
    return (i < srcLog.size()) ? 32'(srcLog[i]) : -1;
  endfunction

  task automatic doReset(input string name);
    @(posedge iClk);
    #3 iRstN = 1'b0;
    #1;
    check({name, "_rst_start"},  32'(oTxStart), 0);
    check({name, "_rst_byte"},   32'(oTxByte),  0);
    check({name, "_rst_busy"},   32'(oBusy),    0);
    check({name, "_rst_src"},    32'(oSrc),     0);
    check({name, "_rst_ready0"}, 32'(oReady0),  1);
    check({name, "_rst_ready1"}, 32'(oReady1),  1);
    repeat (2) @(posedge iClk);
    #3 iRstN = 1'b1;
    repeat (3) @(negedge iClk);
  endtask

  task automatic waitBusy(input string name);
    int n = 0;
    while (oBusy !== 1'b1 && n < 100) begin
      @(negedge iClk);
      n++;
    end
    check(name, 32'(oBusy), 1);
  endtask

  task automatic serveFrame(input string name, input int delay);
    waitBusy(name);
    repeat (delay) @(negedge iClk);
    iTxDone = 1'b1;
    @(negedge iClk);
    iTxDone = 1'b0;
  endtask

  initial begin : mainProc
    // Single byte: start two edges after the push, held busy until done.
    doReset("t1");
    iValid0 = 1'b1; iByte0 = 8'hA5;
    @(negedge iClk);
    iValid0 = 1'b0;
    check("t1_no_early_start", 32'(oTxStart), 0);
    @(negedge iClk);
    check("t1_start", 32'(oTxStart), 1);
    check("t1_byte",  32'(oTxByte),  32'hA5);
    check("t1_src",   32'(oSrc),     0);
    check("t1_busy",  32'(oBusy),    1);
    @(negedge iClk);
    check("t1_start_once", 32'(oTxStart), 0);
    repeat (18) @(negedge iClk);
    check("t1_busy_hold", 32'(oBusy),   1);
    check("t1_byte_hold", 32'(oTxByte), 32'hA5);
    iTxDone = 1'b1;
    @(negedge iClk);
    iTxDone = 1'b0;
    check("t1_idle_after_done", 32'(oBusy), 0);

    // Round-robin between two loaded requesters.
    doReset("t2");
    txLog.delete(); srcLog.delete();
    for (int i = 0; i < 3; i++) begin
      iValid0 = 1'b1; iByte0 = 8'h11 + 8'(i);
      iValid1 = 1'b1; iByte1 = 8'h21 + 8'(i);
      @(negedge iClk);
    end
    iValid0 = 1'b0; iValid1 = 1'b0;
    for (int i = 0; i < 6; i++) serveFrame("t2_busy", 3);
    repeat (5) @(negedge iClk);
    check("t2_frames", txLog.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check("t2_order", logByte(i), 32'(expT2[i]));
      check("t2_src",   logSrc(i),  32'(expS2[i]));
    end

    // Fill requester 1 while the transmitter is stalled on a requester-0 frame.
    doReset("t3");
    txLog.delete(); srcLog.delete();
    iValid0 = 1'b1; iByte0 = 8'h40;
    @(negedge iClk);
    iValid0 = 1'b0;
    waitBusy("t3_busy0");
    for (int i = 0; i < 5; i++) begin
      check("t3_ready_before_push", 32'(oReady1), 32'(i < 4));
      iValid1 = 1'b1; iByte1 = 8'h31 + 8'(i);
      @(negedge iClk);
    end
    iValid1 = 1'b0;
    check("t3_full", 32'(oReady1), 0);
    for (int i = 0; i < 5; i++) serveFrame("t3_busy", 2);
    repeat (10) @(negedge iClk);
    check("t3_frames", txLog.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check("t3_order", logByte(i), 32'(expT3[i]));
      check("t3_src",   logSrc(i),  32'(expS3[i]));
    end
    check("t3_drained_ready", 32'(oReady1), 1);

    // Done held through idle and start, then back-to-back spacing.
    doReset("t4");
    iTxDone = 1'b1;
    repeat (3) @(negedge iClk);
    check("t4_idle_done_busy", 32'(oBusy), 0);
    iValid0 = 1'b1; iByte0 = 8'h55;
    @(negedge iClk);
    iByte0 = 8'h66;
    @(negedge iClk);
    iValid0 = 1'b0;
    check("t4_start", 32'(oTxStart), 1);
    check("t4_byte",  32'(oTxByte),  32'h55);
    @(negedge iClk);
    check("t4_start_ignores_done", 32'(oBusy),   1);
    check("t4_no_extra_pop",       32'(oTxByte), 32'h55);
    iTxDone = 1'b0;
    @(negedge iClk);
    check("t4_still_busy", 32'(oBusy), 1);
    iTxDone = 1'b1;
    @(negedge iClk);
    iTxDone = 1'b0;
    check("t4_gap_start", 32'(oTxStart), 0);
    check("t4_gap_busy",  32'(oBusy),    0);
    @(negedge iClk);
    check("t4_next_start", 32'(oTxStart), 1);
    check("t4_next_byte",  32'(oTxByte),  32'h66);
    serveFrame("t4_busy", 2);

    // Reset in the middle of a frame with two bytes still queued.
    doReset("t5a");
    iValid0 = 1'b1; iByte0 = 8'h77;
    iValid1 = 1'b1; iByte1 = 8'h88;
    @(negedge iClk);
    iValid0 = 1'b0; iByte1 = 8'h99;
    @(negedge iClk);
    iValid1 = 1'b0;
    waitBusy("t5_busy");
    repeat (2) @(negedge iClk);
    check("t5_pre_byte", 32'(oTxByte), 32'h77);
    doReset("t5b");
    txLog.delete(); srcLog.delete();
    repeat (50) @(negedge iClk);
    check("t5_quiet_after_reset", txLog.size(), 0);
    iValid1 = 1'b1; iByte1 = 8'hAB;
    @(negedge iClk);
    iValid1 = 1'b0;
    serveFrame("t5_new_busy", 2);
    repeat (3) @(negedge iClk);
    check("t5_new_frames", txLog.size(), 1);
    check("t5_new_byte",   logByte(0),   32'hAB);
    check("t5_new_src",    logSrc(0),    1);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout, want bench completion");
    $fatal(1, "bench did not complete");
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, bytes buffered per requester (power of 2, >=2).
REQ-002 SHALL have port iClk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port iRstN  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports iValid0/iValid1  input  1 each  requester n offers a byte.
REQ-005 SHALL have ports iByte0/iByte1  input  8 each  requester n byte.
REQ-006 SHALL have ports oReady0/oReady1  output  1 each  requester n FIFO can accept a byte.
REQ-007 SHALL have port oTxStart  output  1  one-cycle start pulse to the shared UART transmitter.
REQ-008 SHALL have port oTxByte  output  8  byte for the transmitter; held stable from oTxStart until iTxDone.
REQ-009 SHALL have port iTxDone  input  1  one-cycle pulse from the transmitter at frame end.
REQ-010 SHALL have port oBusy  output  1  high from oTxStart through the iTxDone cycle.
REQ-011 SHALL have port oSrc  output  1  requester owning the current or last frame.

Function
REQ-012 SHALL push iByteN into FIFO n on any cycle where iValidN and oReadyN are both high.
REQ-013 SHALL drive oReadyN = (FIFO n not full), registered-state based, with no combinational path from iValidN.
REQ-014 SHALL implement FSM states sIDLE, sSTART, sBUSY.
REQ-015 sIDLE: with neither FIFO non-empty, SHALL stay in sIDLE; otherwise SHALL select a requester, pop its head byte into the oTxByte register, set oSrc, and move to sSTART.
REQ-016 Selection SHALL be round-robin: when both FIFOs are non-empty, the requester not granted last wins; when one FIFO is non-empty, it wins; after reset, requester 0 has priority.
REQ-017 sSTART SHALL assert oTxStart for exactly one cycle, then move to sBUSY.
REQ-018 sBUSY SHALL hold oTxByte and oSrc and ignore FIFO contents until iTxDone=1, then update the last-grant pointer and return to sIDLE.
REQ-019 iTxDone outside sBUSY SHALL be ignored.
REQ-020 Latency: a byte pushed at edge N into an empty FIFO, with the FSM in sIDLE and no competing request, SHALL produce oTxStart=1 in cycle N+2.
REQ-021 Back-to-back frames: the iTxDone cycle SHALL be followed by at least one sIDLE cycle, so there are at least 2 cycles from iTxDone to the next oTxStart.
REQ-022 A simultaneous push and pop on the same FIFO SHALL leave its occupancy unchanged and preserve order.
REQ-023 A full FIFO SHALL deassert oReadyN; pushes SHALL be refused and no data SHALL be overwritten. A pop from full SHALL raise oReadyN in the next cycle.
REQ-024 Pointers SHALL wrap modulo FIFO_DEPTH. The occupancy counter SHALL be $clog2(FIFO_DEPTH)+1 bits wide.
REQ-025 Each FIFO SHALL deliver bytes in FIFO order. No byte SHALL be lost or duplicated across arbitration.

Reset
REQ-026 Asserting iRstN=0 SHALL immediately, independent of iClk, set: FSM=sIDLE, both FIFOs empty, oTxStart=0, oTxByte=8'h00, oBusy=0, oSrc=0, last-grant pointer=1 (so requester 0 wins first), oReady0/1=1.
REQ-027 Reset mid-frame (sSTART/sBUSY) SHALL discard the in-flight byte and all buffered bytes. After release, no oTxStart SHALL occur until a new push.
REQ-028 Deassertion SHALL be synchronised internally (2-flop release synchroniser) before the FSM leaves reset.

Structure
REQ-029 The shared package SHALL hold the FSM state encoding (sIDLE=2'b00, sSTART=2'b01, sBUSY=2'b10) and the default FIFO_DEPTH constant.
REQ-030 SHALL instantiate sub-module byte_fifo (synchronous FIFO, 8-bit data, FIFO_DEPTH entries, full/empty/count outputs) once per requester. Arbitration and the FSM SHALL live in the top level.

Verification
REQ-031 Reset, then push 8'hA5 on requester 0 only -> oTxStart at edge+2, oTxByte=8'hA5, oSrc=0; hold oBusy until an iTxDone pulse driven 20 cycles later.
REQ-032 Both requesters push three bytes in the same cycles (0: 11,12,13; 1: 21,22,23) -> transmit order 11,21,12,22,13,23 with oSrc alternating 0,1,0,1,0,1.
REQ-033 Push FIFO_DEPTH+1 bytes on requester 1 while the transmitter is stalled -> oReady1=0 after 4 pushes and the 5th byte is refused. After iTxDone, exactly the first 4 bytes are sent, in order.
REQ-034 Hold iTxDone=1 in sIDLE and in sSTART -> no state change or extra pop. Back-to-back frames -> at least 2 cycles from iTxDone to the next oTxStart.
REQ-035 Assert iRstN=0 mid-sBUSY with 2 bytes queued -> outputs go to reset values asynchronously. After release, with no pushes for 50 cycles, oTxStart stays 0.
